screen_buffer: RTL and testbench
================================

Name: screen_buffer

Overview:
- Receiving end of the renderer's screen-buffer write interface (`sbuf_data`/`sbuf_addr`/`sbuf_write_enable`/`frame_done`).
- Double-buffered RGB565 frame store, 256x128 pixels, row-major. The renderer fills the back bank while the front bank is scanned out to the display pipeline.
- Banks swap at the start of vertical sync once the renderer signals frame completion.
- Scanout applies power-of-two nearest-neighbour upscaling.

Parameters:
- FRAME_WIDTH, 256, pixels per row (power of two).
- FRAME_HEIGHT, 128, rows per frame.
- SCALE_LOG2, 2, log2 of the upscale factor on each axis (default gives 1024x512).
- H_BITS, 11, width of `hcount_in`.
- V_BITS, 10, width of `vcount_in`.

Ports:
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: asynchronous active-low reset.
- `sbuf_data` input 16: RGB565 pixel to write.
- `sbuf_addr` input 16: row-major pixel address.
- `sbuf_write_enable` input 1: write strobe.
- `frame_done` input 1: one-cycle pulse; the back bank is complete.
- `render_ready` output 1: high when the renderer may start a new frame.
- `overrun` output 1: sticky; a write was dropped.
- `hcount_in` input H_BITS: display horizontal position.
- `vcount_in` input V_BITS: display vertical position.
- `active_in` input 1: display active-video region.
- `hsync_in` input 1: display hsync.
- `vsync_in` input 1: display vsync.
- `pixel_out` output 16: RGB565 to display.
- `hsync_out` output 1: hsync delayed to align with `pixel_out`.
- `vsync_out` output 1: vsync delayed to align with `pixel_out`.
- `active_out` output 1: active delayed to align with `pixel_out`.

Behaviour:
- Reset is asynchronous on `rst_n_in` low. During and after reset:
  - `display_bank`=0, `swap_pending`=0, `shown`=0.
  - `render_ready`=1, `overrun`=0.
  - `pixel_out`=0, `hsync_out`=0, `vsync_out`=0, `active_out`=0.
  - The delay pipeline is cleared. RAM contents are not cleared.
- Storage: two banks of FRAME_WIDTH*FRAME_HEIGHT x 16 (2 x 32768 words by default), inferred as BRAM. Each bank has one write port and one read port.
- Write side:
  - The write bank is always `!display_bank`.
  - A write is accepted when `sbuf_write_enable`=1, `sbuf_addr` < FRAME_WIDTH*FRAME_HEIGHT, and `swap_pending`=0. An accepted write becomes visible to reads one cycle later.
  - An out-of-range address is silently ignored and does not set `overrun`.
  - Any write with `swap_pending`=1 is dropped and sets `overrun`. `overrun` clears only on reset.
- Swap:
  - `frame_done`=1 sets `swap_pending`.
  - The swap point is a `vsync_in` rising edge (0 in the previous cycle, 1 now). At that edge with `swap_pending`=1: `display_bank` toggles, `swap_pending` clears, and `shown` sets.
  - `frame_done` coinciding with a vsync rising edge swaps in that same cycle. `swap_pending` then reads 0 the next cycle.
  - A write coinciding with `frame_done` is accepted, because `swap_pending` is still 0 in that cycle.
  - `frame_done` while `swap_pending`=1 has no additional effect.
  - `render_ready` = !`swap_pending` (combinational from the register).
- Scanout, 2-cycle latency from `*_in` to `*_out`:
  - Source pixel coordinates: `px` = `hcount_in` >> SCALE_LOG2, `py` = `vcount_in` >> SCALE_LOG2.
  - In-image condition: `active_in` && `px` < FRAME_WIDTH && `py` < FRAME_HEIGHT.
  - Read address = `py`*FRAME_WIDTH + `px`, formed by shift/concatenation with no multiplier.
  - Stage 1 registers the address, the in-image flag, the bank select, and the syncs.
  - Stage 2 registers the RAM output. `pixel_out` = RAM data if the in-image flag is set and `shown`=1, else 16'h0000.
  - Bank select is sampled at stage 1. A swap mid-line affects only pixels entering stage 1 after the swap.
  - `hsync`/`vsync`/`active` pass through the same two-stage delay unchanged.
  - Outside the image (right/bottom border of the display) `pixel_out` is black.
- Reset mid-frame: all state returns to reset values immediately. The renderer must re-issue the frame; display output is black until the next swap.

Test Plan:
- Reset, then drive scanout with `active_in`=1 over the whole image → `pixel_out`=0 everywhere (`shown`=0); `render_ready`=1.
- Write addr 0 = 16'hF800 and addr 257 = 16'h07E0, pulse `frame_done`, then one vsync rising edge. Scan with SCALE_LOG2=2:
  - `hcount`=0..3, `vcount`=0..3 → `pixel_out`=F800 two cycles later.
  - `hcount`=4..7, `vcount`=4..7 → 07E0.
- After `frame_done` with no vsync edge, issue a write → write dropped, `overrun`=1, `render_ready`=0. After the vsync edge → `render_ready`=1 and `overrun` stays 1.
- `frame_done` and vsync rising edge in the same cycle → `display_bank` toggles that cycle; `render_ready` never goes low (observed cycle-by-cycle).
- Write `sbuf_addr`=16'h8000 (out of range) → no RAM change, `overrun`=0. With `hcount_in`=1024 and `active_in`=1 → `pixel_out`=0.
- Assert `rst_n_in` low asynchronously mid-scan (between clock edges) → all outputs 0 before the next clock edge; after release `render_ready`=1 and the display is black until the next swap.

Source files
------------

// File: rtl/screen_buffer.sv
// Double-buffered RGB565 frame store: the renderer fills the back bank, the front
// bank is scanned out with power-of-two nearest-neighbour upscaling (2-cycle latency).
module screen_buffer #(
   parameter int FRAME_WIDTH  = 256,
   parameter int FRAME_HEIGHT = 128,
   parameter int SCALE_LOG2   = 2,
   parameter int H_BITS       = 11,
   parameter int V_BITS       = 10
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [15:0]       sbuf_data,
   input  logic [15:0]       sbuf_addr,
   input  logic              sbuf_write_enable,
   input  logic              frame_done,
   output logic              render_ready,
   output logic              overrun,
   input  logic [H_BITS-1:0] hcount_in,
   input  logic [V_BITS-1:0] vcount_in,
   input  logic              active_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic [15:0]       pixel_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              active_out
);

   localparam int DEPTH = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int XW    = $clog2(FRAME_WIDTH);
   localparam int YW    = $clog2(FRAME_HEIGHT);
   localparam int AW    = XW + YW;

   // Both banks live in one array; the bank select is the top address bit.
   logic [15:0] r_mem [0:(2**(AW+1))-1];
   logic [15:0] r_rd_data;

   logic          r_display_bank;
   logic          r_swap_pending;
   logic          r_shown;
   logic          r_overrun;

   logic [AW-1:0] r_addr_s1;
   logic          r_show_s1;
   logic          r_bank_s1;
   logic          r_hsync_s1;
   logic          r_vsync_s1;
   logic          r_active_s1;

   logic          r_show_s2;
   logic          r_hsync_s2;
   logic          r_vsync_s2;
   logic          r_active_s2;

   logic              w_wr_in_range;
   logic              w_wr_accept;
   logic              w_vs_rise;
   logic              w_swap;
   logic [H_BITS-1:0] w_px;
   logic [V_BITS-1:0] w_py;
   logic              w_in_image;
   logic [AW-1:0]     w_rd_addr;
   logic              w_unused;

   assign w_wr_in_range = 32'(sbuf_addr) < DEPTH;
   assign w_wr_accept   = sbuf_write_enable & w_wr_in_range & ~r_swap_pending;

   // Stage-1 vsync doubles as the previous-cycle sample for edge detection.
   assign w_vs_rise = vsync_in & ~r_vsync_s1;
   assign w_swap    = w_vs_rise & (r_swap_pending | frame_done);

   assign w_px       = hcount_in >> SCALE_LOG2;
   assign w_py       = vcount_in >> SCALE_LOG2;
   assign w_in_image = active_in && (32'(w_px) < FRAME_WIDTH) && (32'(w_py) < FRAME_HEIGHT);
   assign w_rd_addr  = {w_py[YW-1:0], w_px[XW-1:0]};
   assign w_unused   = ^{hcount_in[SCALE_LOG2-1:0], vcount_in[SCALE_LOG2-1:0]};

   // NOTE: the frame store has no reset so it maps onto block RAM; contents
   // survive a reset and are hidden until the next swap sets r_shown.
   always_ff @(posedge clk_in) begin
      if (w_wr_accept) begin
         r_mem[{~r_display_bank, sbuf_addr[AW-1:0]}] <= sbuf_data;
      end
      r_rd_data <= r_mem[{r_bank_s1, r_addr_s1}];
   end

   // NOTE: every state update uses <= so all registers sample pre-edge values,
   // which is what lets a swap and a same-cycle write see the old bank.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_display_bank <= 1'b0;
         r_swap_pending <= 1'b0;
         r_shown        <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_swap_pending <= ~w_swap & (r_swap_pending | frame_done);
         r_display_bank <= r_display_bank ^ w_swap;
         r_shown        <= r_shown | w_swap;
         r_overrun      <= r_overrun | (sbuf_write_enable & r_swap_pending);
      end
   end

   // Bank and visibility are sampled together with the address, so a mid-line
   // swap only affects pixels that enter stage 1 afterwards.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_addr_s1   <= '0;
         r_show_s1   <= 1'b0;
         r_bank_s1   <= 1'b0;
         r_hsync_s1  <= 1'b0;
         r_vsync_s1  <= 1'b0;
         r_active_s1 <= 1'b0;
         r_show_s2   <= 1'b0;
         r_hsync_s2  <= 1'b0;
         r_vsync_s2  <= 1'b0;
         r_active_s2 <= 1'b0;
      end else begin
         r_addr_s1   <= w_rd_addr;
         r_show_s1   <= w_in_image & r_shown;
         r_bank_s1   <= r_display_bank;
         r_hsync_s1  <= hsync_in;
         r_vsync_s1  <= vsync_in;
         r_active_s1 <= active_in;
         r_show_s2   <= r_show_s1;
         r_hsync_s2  <= r_hsync_s1;
         r_vsync_s2  <= r_vsync_s1;
         r_active_s2 <= r_active_s1;
      end
   end

   assign pixel_out    = r_show_s2 ? r_rd_data : 16'h0000;
   assign hsync_out    = r_hsync_s2;
   assign vsync_out    = r_vsync_s2;
   assign active_out   = r_active_s2;
   assign render_ready = ~r_swap_pending;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_screen_buffer.sv
// Self-checking bench for screen_buffer: directed phases with randomized scan
// traffic compared against a frame-level reference model.
module tb_screen_buffer;

   localparam int W     = 256;
   localparam int H     = 128;
   localparam int S     = 2;
   localparam int HB    = 11;
   localparam int VB    = 10;
   localparam int DEPTH = W * H;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic [15:0]   sbuf_data;
   logic [15:0]   sbuf_addr;
   logic          sbuf_write_enable;
   logic          frame_done;
   logic          render_ready;
   logic          overrun;
   logic [HB-1:0] hcount_in;
   logic [VB-1:0] vcount_in;
   logic          active_in;
   logic          hsync_in;
   logic          vsync_in;
   logic [15:0]   pixel_out;
   logic          hsync_out;
   logic          vsync_out;
   logic          active_out;

   always #5 clk_in = ~clk_in;

   screen_buffer #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .SCALE_LOG2  (S),
      .H_BITS      (HB),
      .V_BITS      (VB)
   ) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .sbuf_data        (sbuf_data),
      .sbuf_addr        (sbuf_addr),
      .sbuf_write_enable(sbuf_write_enable),
      .frame_done       (frame_done),
      .render_ready     (render_ready),
      .overrun          (overrun),
      .hcount_in        (hcount_in),
      .vcount_in        (vcount_in),
      .active_in        (active_in),
      .hsync_in         (hsync_in),
      .vsync_in         (vsync_in),
      .pixel_out        (pixel_out),
      .hsync_out        (hsync_out),
      .vsync_out        (vsync_out),
      .active_out       (active_out)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: two whole frames plus which one is on screen.
   logic [15:0] m_frame [2][DEPTH];
   bit          m_known [2][DEPTH];
   int          m_front;
   bit          m_pending, m_shown, m_overrun, m_prev_vs;

   typedef struct {
      logic [15:0] pix;
      bit          known;
      logic        hs, vs, act;
   } exp_t;
   exp_t m_p1, m_p2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_t z;
      z.pix = 16'h0; z.known = 1'b1; z.hs = 1'b0; z.vs = 1'b0; z.act = 1'b0;
      m_front = 0; m_pending = 0; m_shown = 0; m_overrun = 0; m_prev_vs = 0;
      m_p1 = z; m_p2 = z;
   endtask

   // One clock: predict from the inputs now applied, clock, then compare.
   task automatic step();
      exp_t e;
      int   px, py, a;
      bit   do_swap;
      px = int'(hcount_in) / (1 << S);
      py = int'(vcount_in) / (1 << S);
      e.hs = hsync_in; e.vs = vsync_in; e.act = active_in;
      e.known = 1'b1; e.pix = 16'h0;
      if (active_in && px < W && py < H && m_shown) begin
         e.known = m_known[m_front][py * W + px];
         e.pix   = m_frame[m_front][py * W + px];
      end
      do_swap = vsync_in && !m_prev_vs && (m_pending || frame_done);
      if (sbuf_write_enable) begin
         a = int'(sbuf_addr);
         if (m_pending) m_overrun = 1;
         else if (a < DEPTH) begin
            m_frame[1 - m_front][a] = sbuf_data;
            m_known[1 - m_front][a] = 1'b1;
         end
      end
      if (do_swap) begin
         m_front = 1 - m_front; m_pending = 0; m_shown = 1;
      end else if (frame_done) begin
         m_pending = 1;
      end
      m_prev_vs = vsync_in;
      @(posedge clk_in);
      m_p2 = m_p1;
      m_p1 = e;
      #1;
      check("render_ready", 32'(render_ready), 32'(!m_pending));
      check("overrun", 32'(overrun), 32'(m_overrun));
      check("hsync_out", 32'(hsync_out), 32'(m_p2.hs));
      check("vsync_out", 32'(vsync_out), 32'(m_p2.vs));
      check("active_out", 32'(active_out), 32'(m_p2.act));
      if (m_p2.known) check("pixel_out", 32'(pixel_out), 32'(m_p2.pix));
   endtask

   task automatic idle();
      sbuf_write_enable = 0; frame_done = 0; sbuf_addr = '0; sbuf_data = '0;
      hcount_in = '0; vcount_in = '0; active_in = 0; hsync_in = 0; vsync_in = 0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data);
      sbuf_write_enable = 1; sbuf_addr = addr; sbuf_data = data;
      step();
      sbuf_write_enable = 0;
   endtask

   task automatic vsync_edge();
      vsync_in = 1; step();
      vsync_in = 0; step();
   endtask

   // Show one display position, then flush so its pixel reaches pixel_out.
   task automatic expect_pix(input int h, input int v, input logic [15:0] value);
      hcount_in = HB'(h); vcount_in = VB'(v); active_in = 1;
      step();
      active_in = 0;
      step();
      check($sformatf("pix_h%0d_v%0d", h, v), 32'(pixel_out), 32'(value));
   endtask

   task automatic random_scan(input int n, input int hmax, input int vmax);
      for (int i = 0; i < n; i++) begin
         hcount_in = HB'($urandom_range(0, hmax));
         vcount_in = VB'($urandom_range(0, vmax));
         active_in = 1'($urandom);
         hsync_in  = 1'($urandom);
         vsync_in  = 1'($urandom);
         step();
      end
      idle();
      step();
   endtask

   initial begin
      rst_n_in = 0;
      idle();
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_pixel", 32'(pixel_out), 32'h0);
      check("rst_hsync", 32'(hsync_out), 32'h0);
      check("rst_vsync", 32'(vsync_out), 32'h0);
      check("rst_active", 32'(active_out), 32'h0);
      check("rst_ready", 32'(render_ready), 32'h1);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst_n_in = 1;

      // Nothing shown yet: whole image must be black.
      for (int i = 0; i < 200; i++) begin
         hcount_in = HB'($urandom_range(0, 4 * W - 1));
         vcount_in = VB'($urandom_range(0, 4 * H - 1));
         active_in = 1;
         hsync_in  = 1'($urandom);
         step();
         check("unshown_black", 32'(pixel_out), 32'h0);
      end
      idle();
      step();

      // First frame, including an out-of-range write that must not alias to 0.
      wr(16'd0, 16'hF800);
      wr(16'd257, 16'h07E0);
      wr(16'h8000, 16'h1234);
      step();
      check("oor_overrun", 32'(overrun), 32'h0);
      for (int i = 0; i < 60; i++)
         wr(16'($urandom_range(258, DEPTH - 1)), 16'($urandom));
      frame_done = 1; step(); frame_done = 0;
      check("pending_ready", 32'(render_ready), 32'h0);
      vsync_edge();
      check("swapped_ready", 32'(render_ready), 32'h1);
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 4; h++) expect_pix(h, v, 16'hF800);
      for (int v = 4; v < 8; v++)
         for (int h = 4; h < 8; h++) expect_pix(h, v, 16'h07E0);
      expect_pix(1024, 0, 16'h0000);
      expect_pix(0, 512, 16'h0000);
      random_scan(400, 2047, 1023);

      // Write while a swap is pending is dropped and sets sticky overrun.
      wr(16'd5, 16'hABCD);
      wr(16'd6, 16'h2222);
      frame_done = 1; step(); frame_done = 0;
      wr(16'd6, 16'h1111);
      check("drop_overrun", 32'(overrun), 32'h1);
      check("drop_ready", 32'(render_ready), 32'h0);
      vsync_edge();
      check("after_swap_ready", 32'(render_ready), 32'h1);
      check("overrun_sticky", 32'(overrun), 32'h1);
      expect_pix(20, 0, 16'hABCD);
      expect_pix(24, 0, 16'h2222);

      // frame_done on the vsync edge swaps at once; same-cycle write is kept.
      wr(16'd0, 16'h001F);
      step();
      frame_done = 1; vsync_in = 1;
      sbuf_write_enable = 1; sbuf_addr = 16'd1; sbuf_data = 16'hFFE0;
      step();
      check("coincide_ready0", 32'(render_ready), 32'h1);
      idle();
      step();
      check("coincide_ready1", 32'(render_ready), 32'h1);
      expect_pix(0, 0, 16'h001F);
      expect_pix(5, 2, 16'hFFE0);
      random_scan(200, 1279, 599);

      // Asynchronous reset between clock edges while the scan is visible.
      hcount_in = HB'(0); vcount_in = VB'(0); active_in = 1; hsync_in = 1; vsync_in = 1;
      repeat (4) step();
      check("prereset_pixel", 32'(pixel_out), 32'h001F);
      #2;
      rst_n_in = 0;
      #1;
      check("async_pixel", 32'(pixel_out), 32'h0);
      check("async_hsync", 32'(hsync_out), 32'h0);
      check("async_vsync", 32'(vsync_out), 32'h0);
      check("async_active", 32'(active_out), 32'h0);
      check("async_ready", 32'(render_ready), 32'h1);
      check("async_overrun", 32'(overrun), 32'h0);
      @(posedge clk_in);
      #1;
      rst_n_in = 1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         check("post_reset_black", 32'(pixel_out), 32'h0);
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
